npc_lsu_mem_initiator: RTL and testbench
========================================

# npc_lsu_mem_initiator

Load/store initiator that drives the NPC's 64-bit synchronous data-memory port (valid / wen / raddr / waddr / wdata / wmask / rdata). It accepts one load or store at a time from the execute stage over a valid/ready handshake. It converts each request into a single doubleword-aligned memory access with byte-lane masking, then returns extracted, sign- or zero-extended load data. It sits between the EXU and the memory responder, one request in flight at a time.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width of request and memory address ports.

Ports:
- `clk` in 1: single clock. All state updates on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: EXU request present.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 64: store data, right-aligned (bits [8·2^size−1:0] used).
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0; ignored for stores.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: EXU accepts response.
- `resp_rdata` out 64: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access (only with `LSU_MISALIGN_TRAP_EN`).
- `mem_valid` out 1: memory request strobe.
- `mem_wen` out 1: memory write enable.
- `mem_raddr` out ADDR_W: read address, `req_addr` with [2:0] cleared.
- `mem_waddr` out ADDR_W: write address, `req_addr` with [2:0] cleared.
- `mem_wdata` out 64: store data shifted to its lane, `req_wdata << (8·addr[2:0])`.
- `mem_wmask` out 8: byte-lane mask, `((1<<2^size)−1) << addr[2:0]`.
- `mem_rdata` in 64: doubleword returned by memory, registered by memory one cycle after the `mem_valid` edge.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch wen, addr, wdata, size, and unsigned. Then go to ISSUE, or to RESP with the error flag set if trapping a misaligned access.
- ISSUE: `mem_valid`=1 for exactly one cycle, with `mem_wen` = latched wen and addresses, data, and mask computed from the latched fields. Next state is WAIT.
- WAIT: `mem_valid`=0. For a load, capture `mem_rdata`, shift it right by 8·addr[2:0], truncate to size, and extend per `req_unsigned` into the result register. For a store, the result is 0. Next state is RESP.
- RESP: `resp_valid`=1 with the result and error flag held stable until `resp_ready`. Then go to IDLE.
- Alignment rule: an access is aligned iff `addr mod 2^size == 0`. An aligned access never crosses a doubleword, so there is always exactly one memory access.
- `mem_wdata` and `mem_wmask` are 0 and `mem_wen`=0 in every state except ISSUE.
- `mem_raddr` and `mem_waddr` are both driven with the aligned address in ISSUE and are 0 otherwise.
- Outputs are driven from registered state and latched fields only; there is no combinational path from `req_*` to `mem_*` or `resp_*`.

## Timing
- Request accepted at the posedge ending cycle N. `mem_valid` is high in N+1. `mem_rdata` is valid and captured in N+2. `resp_valid` rises in N+3.
- Load and store latency is 3 cycles from acceptance to `resp_valid`.
- A trapped misaligned access is accepted in N, and `resp_valid` rises in N+1 with no memory access.
- Back-to-back: `resp_valid && resp_ready` in cycle M gives IDLE in M+1, so the next acceptance is earliest at M+1. Minimum issue interval is 4 cycles.
- `resp_ready` held low: the block stays in RESP indefinitely, outputs stable, and `req_ready`=0.
- Reset values: `req_ready`=0 during reset and 1 in the first cycle after `rst_n` goes high. All other outputs are 0, state is IDLE, and latched fields are cleared.
- Reset mid-operation: a low `rst_n` sampled at any edge returns the FSM to IDLE and drops the in-flight request with no response. If reset is sampled in ISSUE, `mem_valid` is 0 from the next cycle; the memory may still complete that one access.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned request takes IDLE→RESP with `resp_err`=1, `resp_rdata`=0, and no `mem_valid` pulse.
- `LSU_MISALIGN_TRAP_EN` undefined: there is no alignment check. The address low bits below the size are forced to 0 (naturally aligned down) and the access proceeds normally; `resp_err` is tied to 0.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles while driving `req_valid`=1. Required: no acceptance; `mem_valid`=0 and `resp_valid`=0 throughout; `req_ready`=1 in the first cycle after release.
- Signed byte load: preload doubleword 0x00000000_0000_8000 at 0x80000000, then load addr 0x80000001, size 0, `req_unsigned`=0. Required:
  - `mem_raddr`=0x80000000, `mem_valid` for one cycle;
  - `resp_rdata`=0xFFFFFFFF_FFFFFF80, `resp_valid` 3 cycles after accept.
- Halfword store: store addr 0x80000006, size 1, wdata 0xBEEF. Required: `mem_waddr`=0x80000000, `mem_wmask`=0xC0, `mem_wdata`=0xBEEF0000_00000000; a subsequent unsigned double load returns the merged value.
- Response backpressure: unsigned word load at 0x80000004 with `resp_ready`=0 for 5 cycles. Required: `resp_valid` and `resp_rdata` held stable, `req_ready`=0, no extra `mem_valid`; IDLE one cycle after `resp_ready`=1.
- Misaligned word load at 0x80000002:
  - with `LSU_MISALIGN_TRAP_EN`: `resp_err`=1 one cycle after accept, no `mem_valid`;
  - without it: access at aligned address 0x80000000, mask-equivalent word extract of bytes 0–3, `resp_err`=0.
- Reset in ISSUE: assert `rst_n`=0 for one cycle during ISSUE of a store. Required: no `resp_valid` is ever produced for that request and `mem_valid`=0 from the next cycle; a new request after reset completes normally.

Source files
------------

// File: rtl/npc_lsu_mem_initiator.sv
// NPC LSU memory initiator: one load/store in flight, 3 cycles from accept to resp_valid, RESP held until resp_ready.
// Build option LSU_MISALIGN_TRAP_EN traps misaligned requests with resp_err; otherwise they are aligned down.
module npc_lsu_mem_initiator #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [63:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_valid,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic [63:0]       mem_rdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e            state_q, state_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [63:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0] req_addr_al;
   logic [2:0]        off;
   logic [63:0]       rd_sh;
   logic [63:0]       rd_ext;
   logic [7:0]        mask_base;
   logic              issue;

   // A naturally aligned access never straddles a doubleword, so aligning down keeps it to one access.
   always_comb begin
      req_addr_al = req_addr;
      case (req_size)
         2'd1:    req_addr_al = {req_addr[ADDR_W-1:1], 1'b0};
         2'd2:    req_addr_al = {req_addr[ADDR_W-1:2], 2'b00};
         2'd3:    req_addr_al = {req_addr[ADDR_W-1:3], 3'b000};
         default: req_addr_al = req_addr;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_q, err_d;
   logic misaligned;

   always_comb begin
      case (req_size)
         2'd1:    misaligned = req_addr[0];
         2'd2:    misaligned = |req_addr[1:0];
         2'd3:    misaligned = |req_addr[2:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign resp_err = resp_valid & err_q;
`else
   assign resp_err = 1'b0;
`endif

   assign off   = addr_q[2:0];
   assign rd_sh = mem_rdata >> {off, 3'b000};

   always_comb begin
      mask_base = 8'hFF;
      rd_ext    = rd_sh;
      case (size_q)
         2'd0: begin
            mask_base = 8'h01;
            rd_ext    = uns_q ? {56'd0, rd_sh[7:0]} : {{56{rd_sh[7]}}, rd_sh[7:0]};
         end
         2'd1: begin
            mask_base = 8'h03;
            rd_ext    = uns_q ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
         end
         2'd2: begin
            mask_base = 8'h0F;
            rd_ext    = uns_q ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
         end
         default: begin
            mask_base = 8'hFF;
            rd_ext    = rd_sh;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      rdata_d = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wen_d   = req_wen;
               addr_d  = req_addr_al;
               wdata_d = req_wdata;
               size_d  = req_size;
               uns_d   = req_unsigned;
               rdata_d = '0;
`ifdef LSU_MISALIGN_TRAP_EN
               err_d   = misaligned;
               state_d = misaligned ? RESP : ISSUE;
`else
               state_d = ISSUE;
`endif
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            rdata_d = wen_q ? 64'd0 : rd_ext;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q   <= err_d;
`endif
      end
   end

   assign issue      = (state_q == ISSUE);
   assign req_ready  = rst_n && (state_q == IDLE);
   assign mem_valid  = issue;
   assign mem_wen    = issue & wen_q;
   assign mem_raddr  = issue ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
   assign mem_waddr  = issue ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
   assign mem_wdata  = issue ? (wdata_q << {off, 3'b000}) : 64'd0;
   assign mem_wmask  = issue ? (mask_base << off) : 8'd0;
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_valid ? rdata_q : 64'd0;
endmodule

// File: tb/tb_npc_lsu_mem_initiator.sv
// Bench for npc_lsu_mem_initiator: registered doubleword memory responder plus a response scoreboard queue.
module tb_npc_lsu_mem_initiator;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [ADDR_W-1:0] req_addr;
   logic [63:0]       req_wdata;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic              resp_valid;
   logic              resp_ready;
   logic [63:0]       resp_rdata;
   logic              resp_err;
   logic              mem_valid;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_raddr;
   logic [ADDR_W-1:0] mem_waddr;
   logic [63:0]       mem_wdata;
   logic [7:0]        mem_wmask;
   logic [63:0]       mem_rdata = 64'd0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int mv_cnt = 0;

   logic [63:0] mem [0:15];
   logic [7:0]  ref_b [0:127];
   logic [64:0] exp_q [$];

   always #5 clk = ~clk;

   npc_lsu_mem_initiator #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_valid === 1'b1) mv_cnt <= mv_cnt + 1;
   end

   always @(posedge clk) begin : responder
      logic [63:0] w;
      if (mem_valid === 1'b1) begin
         mem_rdata <= mem[mem_raddr[6:3]];
         if (mem_wen === 1'b1) begin
            w = mem[mem_waddr[6:3]];
            for (int i = 0; i < 8; i++)
               if (mem_wmask[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            mem[mem_waddr[6:3]] = w;
         end
      end
   end

   task automatic issue(input logic wen, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [1:0] sz, input logic uns, output int acc);
      int n;
      n = 0;
      req_wen = wen; req_addr = addr; req_wdata = wd; req_size = sz; req_unsigned = uns;
      req_valid = 1'b1;
      while (req_ready !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL accept addr=%h: req_ready=%b, required 1 within 30 cycles", addr, req_ready);
         acc = -1;
         req_valid = 1'b0;
      end else begin
         acc = cyc;
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   task automatic wait_resp(output int rc);
      int n;
      n = 0;
      while (resp_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      rc = (resp_valid === 1'b1) ? cyc : -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0000;
      req_wdata = 64'd0; req_size = 2'd3; req_unsigned = 1'b0; resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold[%0d]: mem_valid=%b resp_valid=%b req_ready=%b, required 0 0 0",
                     i, mem_valid, resp_valid, req_ready);
         end
      end
      rst_n = 1'b1; req_valid = 1'b0;
      #1;
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_valid !== 1'b0 || resp_rdata !== 64'd0 ||
          resp_err !== 1'b0 || mem_wmask !== 8'd0 || mem_raddr !== 32'd0) begin
         bad++;
         $display("FAIL reset_release: req_ready=%b resp_valid=%b mem_valid=%b rdata=%h err=%b wmask=%h raddr=%h, required 1 0 0 0 0 0 0",
                  req_ready, resp_valid, mem_valid, resp_rdata, resp_err, mem_wmask, mem_raddr);
      end
      @(negedge clk);
      total++;
      if (mv_cnt !== 0 || mem_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_accept: mem_valid pulses=%0d mem_valid=%b, required 0 0", mv_cnt, mem_valid);
      end
   endtask

   task automatic test_signed_byte_load();
      int acc, rc, mv0;
      logic [64:0] e;
      mem[0] = 64'h0000_0000_0000_8000;
      exp_q.push_back({1'b0, 64'hFFFF_FFFF_FFFF_FF80});
      mv0 = mv_cnt;
      issue(1'b0, 32'h8000_0001, 64'd0, 2'd0, 1'b0, acc);
      total++;
      if (mem_valid !== 1'b1 || mem_raddr !== 32'h8000_0000 || mem_wen !== 1'b0) begin
         bad++;
         $display("FAIL sbyte_issue: mem_valid=%b raddr=%h wen=%b, required 1 80000000 0", mem_valid, mem_raddr, mem_wen);
      end
      @(negedge clk);
      total++;
      if (mem_valid !== 1'b0) begin bad++; $display("FAIL sbyte_pulse: mem_valid=%b in WAIT, required 0", mem_valid); end
      wait_resp(rc);
      total++;
      if (rc < 0 || rc - acc != 3) begin bad++; $display("FAIL sbyte_latency: got %0d cycles, required 3", rc - acc); end
      e = exp_q.pop_front();
      total++;
      if ({resp_err, resp_rdata} !== e) begin
         bad++; $display("FAIL sbyte_data: err=%b rdata=%h, required err=%b rdata=%h", resp_err, resp_rdata, e[64], e[63:0]);
      end
      @(negedge clk);
      total++;
      if (mv_cnt - mv0 != 1 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         bad++; $display("FAIL sbyte_done: pulses=%0d req_ready=%b resp_valid=%b, required 1 1 0", mv_cnt - mv0, req_ready, resp_valid);
      end
   endtask

   task automatic test_halfword_store();
      int acc, rc;
      logic [64:0] e;
      exp_q.push_back({1'b0, 64'd0});
      issue(1'b1, 32'h8000_0006, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0, acc);
      total++;
      if (mem_wen !== 1'b1 || mem_waddr !== 32'h8000_0000 || mem_wmask !== 8'hC0 ||
          mem_wdata !== 64'hBEEF_0000_0000_0000) begin
         bad++;
         $display("FAIL hstore_issue: wen=%b waddr=%h wmask=%h wdata=%h, required 1 80000000 c0 beef000000000000",
                  mem_wen, mem_waddr, mem_wmask, mem_wdata);
      end
      @(negedge clk);
      total++;
      if (mem_wen !== 1'b0 || mem_wmask !== 8'd0 || mem_wdata !== 64'd0 || mem_waddr !== 32'd0) begin
         bad++; $display("FAIL hstore_idle_bus: wen=%b wmask=%h wdata=%h waddr=%h, required all 0", mem_wen, mem_wmask, mem_wdata, mem_waddr);
      end
      wait_resp(rc);
      e = exp_q.pop_front();
      total++;
      if (rc < 0 || rc - acc != 3 || {resp_err, resp_rdata} !== e) begin
         bad++; $display("FAIL hstore_resp: latency=%0d rdata=%h, required 3 %h", rc - acc, resp_rdata, e[63:0]);
      end
      @(negedge clk);
      exp_q.push_back({1'b0, 64'hBEEF_0000_0000_8000});
      issue(1'b0, 32'h8000_0000, 64'd0, 2'd3, 1'b1, acc);
      wait_resp(rc);
      e = exp_q.pop_front();
      total++;
      if (rc < 0 || {resp_err, resp_rdata} !== e) begin
         bad++; $display("FAIL merged_dload: rdata=%h, required %h", resp_rdata, e[63:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int acc, rc, mv0;
      logic [64:0] e;
      resp_ready = 1'b0;
      exp_q.push_back({1'b0, 64'h0000_0000_BEEF_0000});
      mv0 = mv_cnt;
      issue(1'b0, 32'h8000_0004, 64'd0, 2'd2, 1'b1, acc);
      wait_resp(rc);
      total++;
      if (rc < 0 || rc - acc != 3) begin bad++; $display("FAIL bp_latency: got %0d cycles, required 3", rc - acc); end
      e = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (resp_valid !== 1'b1 || {resp_err, resp_rdata} !== e || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: resp_valid=%b rdata=%h req_ready=%b, required 1 %h 0", i, resp_valid, resp_rdata, req_ready, e[63:0]);
         end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      total++;
      if (mv_cnt - mv0 != 1) begin bad++; $display("FAIL bp_pulses: got %0d mem_valid cycles, required 1", mv_cnt - mv0); end
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         bad++; $display("FAIL bp_release: req_ready=%b resp_valid=%b, required 1 0", req_ready, resp_valid);
      end
   endtask

   task automatic test_misaligned();
      int acc, rc, mv0, exp_mv, exp_lat;
      logic [64:0] e;
`ifdef LSU_MISALIGN_TRAP_EN
      exp_mv = 0; exp_lat = 1;
      exp_q.push_back({1'b1, 64'd0});
`else
      exp_mv = 1; exp_lat = 3;
      exp_q.push_back({1'b0, 64'h0000_0000_0000_8000});
`endif
      mv0 = mv_cnt;
      issue(1'b0, 32'h8000_0002, 64'd0, 2'd2, 1'b0, acc);
      total++;
      if (mem_valid !== 1'(exp_mv)) begin bad++; $display("FAIL misalign_strobe: mem_valid=%b, required %0d", mem_valid, exp_mv); end
`ifndef LSU_MISALIGN_TRAP_EN
      total++;
      if (mem_raddr !== 32'h8000_0000) begin bad++; $display("FAIL misalign_addr: raddr=%h, required 80000000", mem_raddr); end
`endif
      wait_resp(rc);
      total++;
      if (rc < 0 || rc - acc != exp_lat) begin bad++; $display("FAIL misalign_latency: got %0d, required %0d", rc - acc, exp_lat); end
      e = exp_q.pop_front();
      total++;
      if ({resp_err, resp_rdata} !== e) begin
         bad++; $display("FAIL misalign_resp: err=%b rdata=%h, required err=%b rdata=%h", resp_err, resp_rdata, e[64], e[63:0]);
      end
      @(negedge clk);
      total++;
      if (mv_cnt - mv0 != exp_mv) begin bad++; $display("FAIL misalign_pulses: got %0d, required %0d", mv_cnt - mv0, exp_mv); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ta [4];
      logic [1:0]  ts [4];
      logic        tu [4];
      logic [63:0] te [4];
      int acc, prev, rc, n;
      logic [64:0] e;
      mem[1] = 64'h8123_4567_89AB_CDEF;
      ta = '{32'h8000_000E, 32'h8000_000C, 32'h8000_0009, 32'h8000_0008};
      ts = '{2'd1, 2'd2, 2'd0, 2'd3};
      tu = '{1'b0, 1'b0, 1'b1, 1'b1};
      te = '{64'hFFFF_FFFF_FFFF_8123, 64'hFFFF_FFFF_8123_4567, 64'h0000_0000_0000_00CD, 64'h8123_4567_89AB_CDEF};
      prev = -1;
      for (int k = 0; k < 4; k++) begin
         req_wen = 1'b0; req_addr = ta[k]; req_wdata = 64'd0; req_size = ts[k]; req_unsigned = tu[k];
         req_valid = 1'b1;
         exp_q.push_back({1'b0, te[k]});
         n = 0;
         while (req_ready !== 1'b1 && n < 30) begin @(negedge clk); n++; end
         acc = cyc;
         total++;
         if (req_ready !== 1'b1 || (k > 0 && acc - prev != 4)) begin
            bad++; $display("FAIL b2b_interval[%0d]: req_ready=%b interval=%0d, required 1 4", k, req_ready, acc - prev);
         end
         prev = acc;
         @(negedge clk);
         wait_resp(rc);
         e = exp_q.pop_front();
         total++;
         if (rc < 0 || {resp_err, resp_rdata} !== e) begin
            bad++; $display("FAIL b2b_data[%0d]: rdata=%h, required %h", k, resp_rdata, e[63:0]);
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      int acc, rc, nb, off, w, base;
      logic [1:0]  sz;
      logic        wen, uns;
      logic [63:0] wd, ev, tmp;
      logic [7:0]  em;
      logic [64:0] e;
      for (int i = 0; i < 16; i++) begin
         tmp = {$urandom, $urandom};
         mem[i] = tmp;
         for (int b = 0; b < 8; b++) ref_b[i*8 + b] = tmp[8*b +: 8];
      end
      for (int k = 0; k < 24; k++) begin
         sz   = 2'($urandom_range(0, 3));
         nb   = 1 << sz;
         off  = int'($urandom_range(0, 7)) & ~(nb - 1);
         w    = int'($urandom_range(0, 15));
         base = w * 8 + off;
         wen  = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         wd   = {$urandom, $urandom};
         ev   = 64'd0;
         em   = 8'd0;
         for (int i = 0; i < nb; i++) em[off + i] = 1'b1;
         if (wen) begin
            for (int i = 0; i < nb; i++) ref_b[base + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < nb; i++) ev[8*i +: 8] = ref_b[base + i];
            if (!uns && ev[8*nb - 1])
               for (int b = 8*nb; b < 64; b++) ev[b] = 1'b1;
         end
         exp_q.push_back({1'b0, ev});
         issue(wen, 32'h8000_0000 + 32'(base), wd, sz, uns, acc);
         if (wen) begin
            total++;
            if (mem_wmask !== em || mem_waddr !== 32'h8000_0000 + 32'(w * 8)) begin
               bad++; $display("FAIL rnd_store[%0d]: wmask=%h waddr=%h, required %h %h", k, mem_wmask, mem_waddr, em, 32'h8000_0000 + 32'(w * 8));
            end
         end
         wait_resp(rc);
         e = exp_q.pop_front();
         total++;
         if (rc < 0 || {resp_err, resp_rdata} !== e) begin
            bad++; $display("FAIL rnd_resp[%0d]: wen=%b size=%0d addr=%h rdata=%h, required %h", k, wen, sz, base, resp_rdata, e[63:0]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_in_issue();
      int acc, rc, seen;
      logic [64:0] e;
      issue(1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 2'd3, 1'b0, acc);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total++;
      if (mem_valid !== 1'b0 || resp_valid !== 1'b0) begin
         bad++; $display("FAIL rst_issue_drop: mem_valid=%b resp_valid=%b, required 0 0", mem_valid, resp_valid);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid === 1'b1) seen++;
         @(negedge clk);
      end
      total++;
      if (seen != 0) begin bad++; $display("FAIL rst_issue_noresp: resp_valid seen %0d cycles, required 0", seen); end
      mem[3] = 64'h0123_4567_CAFE_F00D;
      exp_q.push_back({1'b0, 64'h0000_0000_0123_4567});
      issue(1'b0, 32'h8000_001C, 64'd0, 2'd2, 1'b1, acc);
      wait_resp(rc);
      e = exp_q.pop_front();
      total++;
      if (rc < 0 || rc - acc != 3 || {resp_err, resp_rdata} !== e) begin
         bad++; $display("FAIL rst_issue_next: latency=%0d rdata=%h, required 3 %h", rc - acc, resp_rdata, e[63:0]);
      end
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 64'd0;
      test_reset();
      test_signed_byte_load();
      test_halfword_store();
      test_backpressure();
      test_misaligned();
      test_back_to_back();
      test_random();
      test_reset_in_issue();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
